// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl -- pipeline hazard controller placed beside the instruction
// decoder.
//
// The controller tracks in-flight GRF writers in a Tnew scoreboard that covers
// the NSTAGE stages after D (entry 0 = E). Using that scoreboard it raises a
// D-stage stall when an operand is needed sooner than its producer can deliver
// it. It also picks a forwarding source for each operand. A separate busy
// counter models the multi-cycle mult/div unit and stalls MDU instructions in D.
//
// Optional build macro: HAZ_STATS_EN
//   When it is defined, the block adds output stall_cnt[31:0]. This counter
//   holds the number of stalled cycles, saturates at all-ones, and is cleared
//   by reset.
//
// Ports
//   clk        in   rising-edge clock
//   reset      in   asynchronous, active-high reset
//   D_rs/D_rt  in   source registers read by the D instruction
//   D_tuse_*   in   cycles until the operand is needed; all-ones = unused
//   D_wr       in   D instruction writes the GRF
//   D_a3       in   destination register of the D instruction
//   D_tnew     in   Tnew of the D instruction as it enters E
//   D_md       in   D instruction uses the MDU
//   D_flush    in   D instruction is nullified and enters E as a bubble
//   E_start    in   mult/div issued in E this cycle
//   E_is_div   in   qualifies E_start: 1 = div, 0 = mult
//   stall      out  freeze PC and F/D, insert a bubble into E
//   fwd_rs_sel out  0 = GRF, k = result of stage k-1
//   fwd_rt_sel out  same, for rt
//   md_busy    out  MDU counter nonzero or E_start high
//   stall_cnt  out  (HAZ_STATS_EN only) saturating stall-cycle counter
//
// All outputs are combinational from the registered state and the D inputs,
// so the decision is made in the same cycle as the D instruction.
// -----------------------------------------------------------------------------
module hazard_ctrl #(
    parameter int NSTAGE   = 3,
    parameter int TW       = 2,
    parameter int MULT_CYC = 5,
    parameter int DIV_CYC  = 10,
    parameter int CW       = 4,
    localparam int SELW    = $clog2(NSTAGE + 1)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [4:0]      D_rs,
    input  logic [4:0]      D_rt,
    input  logic [TW-1:0]   D_tuse_rs,
    input  logic [TW-1:0]   D_tuse_rt,
    input  logic            D_wr,
    input  logic [4:0]      D_a3,
    input  logic [TW-1:0]   D_tnew,
    input  logic            D_md,
    input  logic            D_flush,
    input  logic            E_start,
    input  logic            E_is_div,
    output logic            stall,
    output logic [SELW-1:0] fwd_rs_sel,
    output logic [SELW-1:0] fwd_rt_sel,
    output logic            md_busy
`ifdef HAZ_STATS_EN
    ,
    output logic [31:0]     stall_cnt
`endif
);

    // Result of looking one register up in the scoreboard.
    typedef struct packed {
        logic            hit;
        logic [SELW-1:0] idx;
        logic [TW-1:0]   tnew;
    } match_t;

    localparam logic [TW-1:0] TUSE_NONE = {TW{1'b1}};

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [NSTAGE-1:0]          v_q,    v_d;
    logic [NSTAGE-1:0][4:0]     a3_q,   a3_d;
    logic [NSTAGE-1:0][TW-1:0]  tnew_q, tnew_d;
    logic [CW-1:0]              cnt_q,  cnt_d;

    // -------------------------------------------------------------------------
    // Combinational intermediates
    // -------------------------------------------------------------------------
    match_t          rs_m_s;
    match_t          rt_m_s;
    logic            rs_use_s;
    logic            rt_use_s;
    logic            stall_rs_s;
    logic            stall_rt_s;
    logic            stall_md_s;
    logic            md_busy_s;
    logic            stall_s;
    logic [SELW-1:0] fwd_rs_s;
    logic [SELW-1:0] fwd_rt_s;

    // -------------------------------------------------------------------------
    // Helpers
    // -------------------------------------------------------------------------

    // Decrement a Tnew value, stopping at zero. A result is never "less than ready".
    function automatic logic [TW-1:0] dec_sat(input logic [TW-1:0] t);
        logic [TW-1:0] r;
        if (t == {TW{1'b0}}) begin
            r = {TW{1'b0}};
        end else begin
            r = t - {{(TW-1){1'b0}}, 1'b1};
        end
        return r;
    endfunction

    // Find the youngest valid entry that writes register r. The scan runs from
    // the oldest entry to the youngest, so a later (lower-index) hit overwrites
    // an earlier one. Older writers to the same register are shadowed.
    function automatic match_t lookup(
        input logic [4:0]                r,
        input logic [NSTAGE-1:0]         v,
        input logic [NSTAGE-1:0][4:0]    a3,
        input logic [NSTAGE-1:0][TW-1:0] tn
    );
        match_t m;
        m.hit  = 1'b0;
        m.idx  = {SELW{1'b0}};
        m.tnew = {TW{1'b0}};
        for (int i = NSTAGE - 1; i >= 0; i--) begin
            if (v[i] && (a3[i] == r)) begin
                m.hit  = 1'b1;
                m.idx  = SELW'(i);
                m.tnew = tn[i];
            end else begin
                m = m;
            end
        end
        return m;
    endfunction

    // -------------------------------------------------------------------------
    // Operand lookups
    // -------------------------------------------------------------------------

    // An operand takes part only if it is a real register and is actually read.
    always_comb begin
        rs_use_s = (D_rs != 5'd0) && (D_tuse_rs != TUSE_NONE);
        rt_use_s = (D_rt != 5'd0) && (D_tuse_rt != TUSE_NONE);
        rs_m_s   = lookup(D_rs, v_q, a3_q, tnew_q);
        rt_m_s   = lookup(D_rt, v_q, a3_q, tnew_q);
    end

    // Stall and forward decisions for rs.
    always_comb begin
        stall_rs_s = 1'b0;
        fwd_rs_s   = {SELW{1'b0}};
        if (rs_use_s && rs_m_s.hit) begin
            stall_rs_s = (rs_m_s.tnew > D_tuse_rs);
            if (rs_m_s.tnew == {TW{1'b0}}) begin
                fwd_rs_s = rs_m_s.idx + SELW'(1);
            end else begin
                fwd_rs_s = {SELW{1'b0}};
            end
        end else begin
            stall_rs_s = 1'b0;
            fwd_rs_s   = {SELW{1'b0}};
        end
    end

    // Stall and forward decisions for rt.
    always_comb begin
        stall_rt_s = 1'b0;
        fwd_rt_s   = {SELW{1'b0}};
        if (rt_use_s && rt_m_s.hit) begin
            stall_rt_s = (rt_m_s.tnew > D_tuse_rt);
            if (rt_m_s.tnew == {TW{1'b0}}) begin
                fwd_rt_s = rt_m_s.idx + SELW'(1);
            end else begin
                fwd_rt_s = {SELW{1'b0}};
            end
        end else begin
            stall_rt_s = 1'b0;
            fwd_rt_s   = {SELW{1'b0}};
        end
    end

    // MDU occupancy and the combined stall. E_start counts as busy in its issue
    // cycle, before the counter has been loaded.
    always_comb begin
        md_busy_s  = (cnt_q != {CW{1'b0}}) | E_start;
        stall_md_s = D_md & md_busy_s;
        stall_s    = stall_rs_s | stall_rt_s | stall_md_s;
    end

    // -------------------------------------------------------------------------
    // Scoreboard
    // -------------------------------------------------------------------------

    // Next scoreboard state. Every entry ages by one stage on each edge, even
    // while stalled. Only the insertion into E turns into a bubble, and a
    // stall together with a flush still inserts a single bubble.
    always_comb begin
        v_d    = v_q;
        a3_d   = a3_q;
        tnew_d = tnew_q;
        for (int i = 1; i < NSTAGE; i++) begin
            v_d[i]    = v_q[i-1];
            a3_d[i]   = a3_q[i-1];
            tnew_d[i] = dec_sat(tnew_q[i-1]);
        end
        if (stall_s || D_flush) begin
            v_d[0]    = 1'b0;
            a3_d[0]   = D_a3;
            tnew_d[0] = D_tnew;
        end else begin
            // Writes to $0 are discarded, so they must never produce a match.
            v_d[0]    = D_wr & (D_a3 != 5'd0);
            a3_d[0]   = D_a3;
            tnew_d[0] = D_tnew;
        end
    end

    // Scoreboard registers. Only the valid bits and Tnew values need a reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            v_q    <= {NSTAGE{1'b0}};
            a3_q   <= '0;
            tnew_q <= '0;
        end else begin
            v_q    <= v_d;
            a3_q   <= a3_d;
            tnew_q <= tnew_d;
        end
    end

    // -------------------------------------------------------------------------
    // MDU busy counter
    // -------------------------------------------------------------------------

    // Next MDU count. A start is accepted only when the unit is idle. A start
    // that arrives while the count is nonzero does not reload the counter.
    always_comb begin
        cnt_d = cnt_q;
        if (E_start && (cnt_q == {CW{1'b0}})) begin
            if (E_is_div) begin
                cnt_d = CW'(DIV_CYC);
            end else begin
                cnt_d = CW'(MULT_CYC);
            end
        end else if (cnt_q != {CW{1'b0}}) begin
            cnt_d = cnt_q - {{(CW-1){1'b0}}, 1'b1};
        end else begin
            cnt_d = {CW{1'b0}};
        end
    end

    // MDU counter register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= {CW{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign stall      = stall_s;
    assign fwd_rs_sel = fwd_rs_s;
    assign fwd_rt_sel = fwd_rt_s;
    assign md_busy    = md_busy_s;

`ifdef HAZ_STATS_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;

    // Next stall-cycle count. It saturates instead of wrapping.
    always_comb begin
        if (stall_s && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
    end

    // Stall-cycle counter register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt_q <= 32'd0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// Testbench for hazard_ctrl. Directed scenarios are checked against known
// values. A randomized run is checked against a reference model that keeps
// the recently issued instructions in a list ordered by age, plus the issue
// window of the last accepted mult/div.
// -----------------------------------------------------------------------------
module tb_hazard_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] D_rs, D_rt, D_a3;
    logic [1:0] D_tuse_rs, D_tuse_rt, D_tnew;
    logic       D_wr, D_md, D_flush, E_start, E_is_div;
    logic       stall, md_busy;
    logic [1:0] fwd_rs_sel, fwd_rt_sel;
`ifdef HAZ_STATS_EN
    logic [31:0] stall_cnt;
`endif

    hazard_ctrl dut (
        .clk(clk), .reset(reset),
        .D_rs(D_rs), .D_rt(D_rt), .D_tuse_rs(D_tuse_rs), .D_tuse_rt(D_tuse_rt),
        .D_wr(D_wr), .D_a3(D_a3), .D_tnew(D_tnew), .D_md(D_md), .D_flush(D_flush),
        .E_start(E_start), .E_is_div(E_is_div),
        .stall(stall), .fwd_rs_sel(fwd_rs_sel), .fwd_rt_sel(fwd_rt_sel),
        .md_busy(md_busy)
`ifdef HAZ_STATS_EN
        , .stall_cnt(stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // ---------------- reference model ----------------
    typedef struct {
        bit         wr;
        logic [4:0] a3;
        int         tnew0;
    } rec_t;
    rec_t hq[$];          // index k = instruction that entered E k edges ago
    int   cyc = 1;
    int   mdu_start = 0;  // cycle when the last accepted mult/div was issued
    int   mdu_end = 0;    // last cycle in which its counter is still nonzero
    int   m_scnt = 0;
    bit   e_stall, e_busy;
    int   e_rs, e_rt;

    function automatic void m_lookup(input logic [4:0] r, input logic [1:0] tu,
                                     output bit st, output int sel);
        st  = 1'b0;
        sel = 0;
        if (r != 5'd0 && tu != 2'b11) begin
            for (int k = 0; k < hq.size(); k++) begin
                if (hq[k].wr && hq[k].a3 == r) begin
                    int t;
                    t = hq[k].tnew0 - k;
                    if (t < 0) t = 0;
                    st  = (t > int'(tu));
                    sel = (t == 0) ? k + 1 : 0;
                    break;
                end
            end
        end
    endfunction

    function automatic bit cnt_busy();
        return (cyc > mdu_start) && (cyc <= mdu_end);
    endfunction

    function automatic void m_eval();
        bit s_rs, s_rt;
        m_lookup(D_rs, D_tuse_rs, s_rs, e_rs);
        m_lookup(D_rt, D_tuse_rt, s_rt, e_rt);
        e_busy  = E_start | cnt_busy();
        e_stall = s_rs | s_rt | (D_md & e_busy);
    endfunction

    function automatic void m_reset();
        hq.delete();
        mdu_start = cyc;
        mdu_end   = cyc;
        m_scnt    = 0;
    endfunction

    // Advance one clock edge and update the model from the inputs applied.
    task automatic tick();
        rec_t r;
        m_eval();
        @(posedge clk);
        r.wr    = !e_stall && !D_flush && D_wr && (D_a3 != 5'd0);
        r.a3    = D_a3;
        r.tnew0 = int'(D_tnew);
        hq.push_front(r);
        if (hq.size() > 3) void'(hq.pop_back());
        if (E_start && !cnt_busy()) begin
            mdu_start = cyc;
            mdu_end   = cyc + (E_is_div ? 10 : 5);
        end
        if (e_stall) m_scnt++;
        cyc++;
        #1;
    endtask

    task automatic idle();
        D_rs = 5'd0; D_rt = 5'd0; D_tuse_rs = 2'b11; D_tuse_rt = 2'b11;
        D_wr = 1'b0; D_a3 = 5'd0; D_tnew = 2'd0; D_md = 1'b0; D_flush = 1'b0;
        E_start = 1'b0; E_is_div = 1'b0;
    endtask

    task automatic drain();
        idle();
        repeat (4) tick();
    endtask

    task automatic writer(input logic [4:0] a3, input logic [1:0] tn);
        idle();
        D_wr = 1'b1; D_a3 = a3; D_tnew = tn;
        tick();
        idle();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        D_rs = 5'd1; D_rt = 5'd2; D_tuse_rs = 2'd0; D_tuse_rt = 2'd0; D_md = 1'b1;
        @(negedge clk);
        n_vec++; if (stall !== 1'b0) begin n_err++; $display("FAIL reset_stall: got %b want 0", stall); end
        n_vec++; if (fwd_rs_sel !== 2'd0) begin n_err++; $display("FAIL reset_fwd_rs: got %0d want 0", fwd_rs_sel); end
        n_vec++; if (fwd_rt_sel !== 2'd0) begin n_err++; $display("FAIL reset_fwd_rt: got %0d want 0", fwd_rt_sel); end
        n_vec++; if (md_busy !== 1'b0) begin n_err++; $display("FAIL reset_md_busy: got %b want 0", md_busy); end
`ifdef HAZ_STATS_EN
        n_vec++; if (stall_cnt !== 32'd0) begin n_err++; $display("FAIL reset_stall_cnt: got %0d want 0", stall_cnt); end
`endif
        reset = 1'b0;
        m_reset();
        idle();
    endtask

    task automatic test_alu_fwd();
        writer(5'd1, 2'd1);
        D_rs = 5'd1; D_tuse_rs = 2'd0;
        @(negedge clk);
        n_vec++; if (stall !== 1'b1) begin n_err++; $display("FAIL alu_stall1: got %b want 1", stall); end
        tick();
        @(negedge clk);
        n_vec++; if (stall !== 1'b0) begin n_err++; $display("FAIL alu_stall2: got %b want 0", stall); end
        n_vec++; if (fwd_rs_sel !== 2'd2) begin n_err++; $display("FAIL alu_fwd: got %0d want 2", fwd_rs_sel); end
        drain();
    endtask

    task automatic test_load_use();
        writer(5'd5, 2'd2);
        D_rt = 5'd5; D_tuse_rt = 2'd1;
        @(negedge clk);
        n_vec++; if (stall !== 1'b1) begin n_err++; $display("FAIL load1_stall: got %b want 1", stall); end
        tick();
        @(negedge clk);
        n_vec++; if (stall !== 1'b0) begin n_err++; $display("FAIL load1_release: got %b want 0", stall); end
        n_vec++; if (fwd_rt_sel !== 2'd0) begin n_err++; $display("FAIL load1_fwd: got %0d want 0", fwd_rt_sel); end
        drain();
        writer(5'd5, 2'd2);
        D_rt = 5'd5; D_tuse_rt = 2'd0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            n_vec++; if (stall !== 1'b1) begin n_err++; $display("FAIL load0_stall[%0d]: got %b want 1", i, stall); end
            tick();
        end
        @(negedge clk);
        n_vec++; if (stall !== 1'b0) begin n_err++; $display("FAIL load0_release: got %b want 0", stall); end
        n_vec++; if (fwd_rt_sel !== 2'd3) begin n_err++; $display("FAIL load0_fwd: got %0d want 3", fwd_rt_sel); end
        drain();
    endtask

    task automatic test_zero_unused();
        writer(5'd0, 2'd1);
        D_rs = 5'd0; D_tuse_rs = 2'd0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            n_vec++; if (stall !== 1'b0 || fwd_rs_sel !== 2'd0) begin
                n_err++; $display("FAIL zero_reg[%0d]: got stall=%b sel=%0d want 0/0", i, stall, fwd_rs_sel); end
            tick();
        end
        drain();
        writer(5'd6, 2'd2);
        D_rs = 5'd6; D_rt = 5'd6; D_tuse_rs = 2'b11; D_tuse_rt = 2'b11;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_vec++; if (stall !== 1'b0 || fwd_rs_sel !== 2'd0 || fwd_rt_sel !== 2'd0) begin
                n_err++; $display("FAIL unused[%0d]: got stall=%b rs=%0d rt=%0d want 0/0/0", i, stall, fwd_rs_sel, fwd_rt_sel); end
            tick();
        end
        drain();
    endtask

    task automatic test_youngest();
        writer(5'd2, 2'd0);
        writer(5'd2, 2'd0);
        D_rs = 5'd2; D_rt = 5'd2; D_tuse_rs = 2'd0; D_tuse_rt = 2'd0;
        @(negedge clk);
        n_vec++; if (fwd_rs_sel !== 2'd1) begin n_err++; $display("FAIL youngest_rs: got %0d want 1", fwd_rs_sel); end
        n_vec++; if (fwd_rt_sel !== 2'd1) begin n_err++; $display("FAIL youngest_rt: got %0d want 1", fwd_rt_sel); end
        n_vec++; if (stall !== 1'b0) begin n_err++; $display("FAIL youngest_stall: got %b want 0", stall); end
        drain();
    endtask

    task automatic test_mdu();
        idle();
        E_start = 1'b1; E_is_div = 1'b1; D_md = 1'b1;
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            n_vec++; if (md_busy !== 1'b1 || stall !== 1'b1) begin
                n_err++; $display("FAIL mdu_busy[%0d]: got busy=%b stall=%b want 1/1", i, md_busy, stall); end
            tick();
            E_start = 1'b0;
        end
        @(negedge clk);
        n_vec++; if (md_busy !== 1'b0 || stall !== 1'b0) begin
            n_err++; $display("FAIL mdu_done: got busy=%b stall=%b want 0/0", md_busy, stall); end
        drain();
    endtask

    task automatic test_reset_midop();
        idle();
        E_start = 1'b1; E_is_div = 1'b1;
        tick();
        idle();
        tick();
        tick();
        D_wr = 1'b1; D_a3 = 5'd3; D_tnew = 2'd0;
        tick();                       // counter now 7, s[0] writes $3
        idle();
        D_rs = 5'd3; D_tuse_rs = 2'd0; D_md = 1'b1;
        @(negedge clk);
        n_vec++; if (md_busy !== 1'b1 || fwd_rs_sel !== 2'd1 || stall !== 1'b1) begin
            n_err++; $display("FAIL midop_pre: got busy=%b sel=%0d stall=%b want 1/1/1", md_busy, fwd_rs_sel, stall); end
        reset = 1'b1;
        #1;
        m_reset();
        n_vec++; if (md_busy !== 1'b0 || fwd_rs_sel !== 2'd0 || stall !== 1'b0) begin
            n_err++; $display("FAIL midop_reset: got busy=%b sel=%0d stall=%b want 0/0/0", md_busy, fwd_rs_sel, stall); end
`ifdef HAZ_STATS_EN
        n_vec++; if (stall_cnt !== 32'd0) begin n_err++; $display("FAIL midop_stall_cnt: got %0d want 0", stall_cnt); end
`endif
        #1;
        reset = 1'b0;
        drain();
    endtask

    task automatic test_random();
        for (int n = 0; n < 600; n++) begin
            D_rs      = 5'($urandom_range(0, 7));
            D_rt      = 5'($urandom_range(0, 7));
            D_tuse_rs = 2'($urandom_range(0, 3));
            D_tuse_rt = 2'($urandom_range(0, 3));
            D_wr      = ($urandom_range(0, 3) != 0);
            D_a3      = 5'($urandom_range(0, 7));
            D_tnew    = 2'($urandom_range(0, 3));
            D_md      = ($urandom_range(0, 5) == 0);
            D_flush   = ($urandom_range(0, 7) == 0);
            E_start   = ($urandom_range(0, 9) == 0);
            E_is_div  = 1'($urandom_range(0, 1));
            @(negedge clk);
            m_eval();
            n_vec++; if (stall !== e_stall) begin n_err++; $display("FAIL rnd_stall[%0d]: got %b want %b", n, stall, e_stall); end
            n_vec++; if (fwd_rs_sel !== 2'(e_rs)) begin n_err++; $display("FAIL rnd_fwd_rs[%0d]: got %0d want %0d", n, fwd_rs_sel, e_rs); end
            n_vec++; if (fwd_rt_sel !== 2'(e_rt)) begin n_err++; $display("FAIL rnd_fwd_rt[%0d]: got %0d want %0d", n, fwd_rt_sel, e_rt); end
            n_vec++; if (md_busy !== e_busy) begin n_err++; $display("FAIL rnd_md_busy[%0d]: got %b want %b", n, md_busy, e_busy); end
`ifdef HAZ_STATS_EN
            n_vec++; if (stall_cnt !== 32'(m_scnt)) begin n_err++; $display("FAIL rnd_stall_cnt[%0d]: got %0d want %0d", n, stall_cnt, m_scnt); end
`endif
            tick();
        end
        drain();
    endtask

    initial begin
        reset = 1'b1;
        idle();
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_alu_fwd();
        test_load_use();
        test_zero_unused();
        test_youngest();
        test_mdu();
        test_reset_midop();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Parametrised pipeline hazard controller that sits beside the instruction decoder.
- Tracks in-flight register writers in a Tnew scoreboard over NSTAGE post-decode stages (E, M, W, ...).
- Raises a D-stage stall on Tuse/Tnew conflicts and selects per-operand forwarding sources.
- Sequences a multi-cycle mult/div busy counter that stalls MDU-type instructions in D.

Parameters:
NSTAGE, 3, number of tracked stages after D (index 0 = E)
TW, 2, width of Tuse/Tnew fields
MULT_CYC, 5, busy cycles for multiply
DIV_CYC, 10, busy cycles for divide
CW, 4, busy counter width; must hold DIV_CYC

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high
D_rs  in  5  rs register read by the D instruction
D_rt  in  5  rt register read by the D instruction
D_tuse_rs  in  TW  cycles until rs is needed; all-ones = not used
D_tuse_rt  in  TW  same, for rt
D_wr  in  1  D instruction writes the GRF
D_a3  in  5  destination register of the D instruction
D_tnew  in  TW  Tnew of the D instruction as it enters E
D_md  in  1  D instruction uses the MDU (mult/div/mfhi/mflo/mthi/mtlo)
D_flush  in  1  D instruction nullified; enters E as a bubble
E_start  in  1  mult/div issued in E this cycle
E_is_div  in  1  qualifies E_start: 1 = div, 0 = mult
stall  out  1  freeze PC and F/D, insert bubble into E
fwd_rs_sel  out  SELW  0 = GRF, k = stage k-1 result; SELW = $clog2(NSTAGE+1)
fwd_rt_sel  out  SELW  same, for rt
md_busy  out  1  MDU counter nonzero or E_start high

Behaviour:
- Scoreboard state: entries s[0..NSTAGE-1], each holding {v, a3, tnew}.
- Reset (async): all v=0, tnew=0, busy counter=0. Resulting outputs: stall=0, fwd_*_sel=0, md_busy=0. Reset mid-operation clears in-flight entries and the busy count immediately.
- Each clock edge:
  - s[i] <= s[i-1] for i>=1, with tnew decremented and saturating at 0.
  - s[0] <= bubble (v=0) if stall or D_flush; otherwise {D_wr & (D_a3!=0), D_a3, D_tnew}.
  - The scoreboard shifts even during a stall; only the E insertion becomes a bubble.
- Match, per operand r (rs or rt):
  - Match only if r!=0 and tuse != all-ones.
  - Choose the youngest (lowest index) valid entry with a3==r. Older matches are ignored.
- Stall: stall_r = match & (s[j].tnew > tuse). stall = stall_rs | stall_rt | stall_md.
- Forwarding select: fwd_r_sel = j+1 if matched and s[j].tnew==0, else 0. Computed even when stall=1.
- MDU counter:
  - E_start with count==0 loads DIV_CYC or MULT_CYC.
  - Otherwise the counter decrements to 0 and holds there.
  - E_start while count!=0 is ignored; no reload.
  - md_busy = (count!=0) | E_start. stall_md = D_md & md_busy.
- All outputs are combinational from state plus D inputs; there is no additional latency.
- Simultaneous stall and D_flush: a single bubble is inserted.

Optional Feature:
- Macro: HAZ_STATS_EN.
- Defined: adds output stall_cnt [31:0]. It increments on every cycle with stall=1, saturates at 32'hFFFF_FFFF, and resets to 0 asynchronously.
- Undefined: the port and counter do not exist; all other behaviour is identical.

Test Plan:
- ALU writer then reader: D_wr=1, D_a3=1, D_tnew=1, then next D has D_rs=1, D_tuse_rs=0 -> stall=1 for exactly 1 cycle, then stall=0 and fwd_rs_sel=2 (M).
- Load-use: D_tnew=2 on $5, next D_rt=5, tuse=1 -> stall=1 for 1 cycle, then stall=0 with fwd_rt_sel=0; with tuse=0 -> 2 stall cycles, then fwd_rt_sel=3 (W).
- $0 and unused operands: writer has D_a3=0, or reader has tuse=all-ones -> stall=0, fwd_*_sel=0 throughout.
- Youngest priority: two back-to-back writers to $2 with D_tnew=0 -> a D read of $2 gives fwd_rs_sel=1.
- MDU: E_start=1, E_is_div=1 -> md_busy high for 11 cycles (start + 10); D_md=1 during that window -> stall=1; D_md=1 on the next cycle -> stall=0.
- Reset mid-op: assert reset with count=7 and s[0] valid -> md_busy=0, stall=0, fwd_*_sel=0 before the next clk edge. With HAZ_STATS_EN defined, stall_cnt reads 0.
